// File: rtl/uart_tx_ctrl_if.sv
// Signal bundle joining the UART TX frame sequencer to its word source and
// to the external serializer. fsm_state exposes the sequencer state for checkers.
interface uart_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             Data_Valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             ser_data;
    logic             ser_done;
    logic             ser_en;
    logic             Busy;
    logic             TX_OUT;
    logic             frame_done;
    logic             seq_err;
    logic [2:0]       fsm_state;

    // Handshake: Busy is the inverted ready. A word transfers on the rising edge
    // where Data_Valid=1 and Busy=0. P_DATA/PAR_EN/PAR_TYP matter only on that edge.
    // Data_Valid while Busy=1 is ignored, and the source may hold it high.
    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, Busy, TX_OUT, frame_done, seq_err, fsm_state
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, Busy, TX_OUT, frame_done, seq_err, fsm_state
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, serializer data bits, optional parity,
// stop bit, with a watchdog that ends the frame if the serializer never reports done.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] WD_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          par_reg;
    logic          par_en_reg;
    logic          wd_err_reg;
    logic [CW-1:0] wd_cnt;
    logic          accept;
    logic          wd_expire;

    logic          tx_bit;
    logic          busy;
    logic          shift_en;
    logic          done_pulse;
    logic          err_pulse;

    assign accept    = (state == IDLE) && bus.Data_Valid;
    assign wd_expire = (state == DATA) && !bus.ser_done && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Parity and parity enable are frozen at acceptance so mid-frame input changes are harmless.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_reg    <= 1'b0;
            par_en_reg <= 1'b0;
            wd_err_reg <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (accept) begin
                par_reg    <= (^bus.P_DATA) ^ bus.PAR_TYP;
                par_en_reg <= bus.PAR_EN;
                wd_err_reg <= 1'b0;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == DATA) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (wd_expire) begin
                wd_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        tx_bit     = 1'b1;
        busy       = 1'b0;
        shift_en   = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    state_next = START;
                end
            end
            START: begin
                tx_bit     = 1'b0;
                busy       = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                tx_bit   = bus.ser_data;
                busy     = 1'b1;
                shift_en = 1'b1;
                if (bus.ser_done) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end else if (wd_cnt == WD_LAST) begin
                    // Serializer stalled: close the frame, skipping parity.
                    state_next = STOP;
                end
            end
            PARITY: begin
                tx_bit     = par_reg;
                busy       = 1'b1;
                state_next = STOP;
            end
            STOP: begin
                busy       = 1'b1;
                done_pulse = 1'b1;
                err_pulse  = wd_err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.TX_OUT     = tx_bit;
    assign bus.Busy       = busy;
    assign bus.ser_en     = shift_en;
    assign bus.frame_done = done_pulse;
    assign bus.seq_err    = err_pulse;
    assign bus.fsm_state  = state;

    a_shift_only_busy : assert property (@(posedge CLK) disable iff (RST) bus.ser_en |-> bus.Busy);
    a_stop_is_high    : assert property (@(posedge CLK) disable iff (RST) bus.frame_done |-> bus.TX_OUT);
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural LSB-first serializer attached; expected
// line bits are queued when a word is driven and drained as the frame is observed.
module tb_uart_tx_ctrl;
    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_tx_ctrl_if #(.WIDTH(WIDTH)) bus ();

    uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Serializer model: loads whenever Busy=0, shifts on ser_en, done on its last bit.
    logic [WIDTH-1:0] sr;
    logic [7:0]       scnt;
    logic             stall = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            sr   <= '0;
            scnt <= '0;
        end else if (!bus.Busy) begin
            sr   <= bus.P_DATA;
            scnt <= '0;
        end else if (bus.ser_en) begin
            sr   <= sr >> 1;
            scnt <= scnt + 8'd1;
        end
    end

    assign bus.ser_data = sr[0];
    assign bus.ser_done = !stall && (scnt == 8'(WIDTH - 1));

    int         n_pass = 0;
    int         n_total = 0;
    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];
    int         busy_cycles, fd_count, fd_pos, sen_count, serr_count, serr_pos;
    bit         timed_out;

    initial begin
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic push_frame(input logic [WIDTH-1:0] d, input logic pen, input logic ptyp);
        exp_q.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(d[i]);
        if (pen) exp_q.push_back((^d) ^ ptyp);
        exp_q.push_back(1'b1);
    endtask

    // Called at a negedge in IDLE; returns at the START negedge.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic pen, input logic ptyp,
                             input logic keep_valid);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        if (!keep_valid) bus.Data_Valid = 1'b0;
    endtask

    // Records every Busy cycle of one frame; returns at the first negedge with Busy=0.
    task automatic capture_frame();
        obs_q.delete();
        busy_cycles = 0; fd_count = 0; fd_pos = 0;
        sen_count = 0; serr_count = 0; serr_pos = 0;
        timed_out = 1'b0;
        for (int i = 0; i < 4 && bus.Busy !== 1'b1; i++) @(negedge CLK);
        if (bus.Busy !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        while (bus.Busy === 1'b1) begin
            if (busy_cycles >= 40) begin
                timed_out = 1'b1;
                return;
            end
            obs_q.push_back(bus.TX_OUT);
            busy_cycles++;
            if (bus.frame_done === 1'b1) begin fd_count++; fd_pos = busy_cycles; end
            if (bus.ser_en === 1'b1) sen_count++;
            if (bus.seq_err === 1'b1) begin serr_count++; serr_pos = busy_cycles; end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_total++;
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0 || bus.ser_en !== 1'b0 ||
                bus.frame_done !== 1'b0 || bus.seq_err !== 1'b0)
                $display("FAIL reset_hold%0d: TX_OUT=%b Busy=%b ser_en=%b frame_done=%b seq_err=%b, required 1 0 0 0 0",
                         i, bus.TX_OUT, bus.Busy, bus.ser_en, bus.frame_done, bus.seq_err);
            else n_pass++;
        end
        RST = 1'b0;
        push_frame(8'h3C, 1'b0, 1'b0);
        @(negedge CLK);
        n_total++;
        if (bus.Busy !== 1'b1) $display("FAIL reset_first_accept: Busy=%b, required 1", bus.Busy);
        else n_pass++;
        bus.Data_Valid = 1'b0;
        capture_frame();
        n_total++;
        if (timed_out !== 1'b0) $display("FAIL reset_timeout: timed_out=%b, required 0", timed_out);
        else n_pass++;
        n_total++;
        if (busy_cycles !== 10) $display("FAIL reset_busy_len: got %0d, required 10", busy_cycles);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL reset_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL reset_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_even_parity();
        push_frame(8'hA5, 1'b1, 1'b0);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        capture_frame();
        n_total++;
        if (timed_out !== 1'b0) $display("FAIL even_timeout: timed_out=%b, required 0", timed_out);
        else n_pass++;
        n_total++;
        if (busy_cycles !== 11) $display("FAIL even_busy_len: got %0d, required 11", busy_cycles);
        else n_pass++;
        n_total++;
        if (fd_count !== 1 || fd_pos !== 11)
            $display("FAIL even_frame_done: count %0d at %0d, required 1 at 11", fd_count, fd_pos);
        else n_pass++;
        n_total++;
        if (sen_count !== 8) $display("FAIL even_ser_en: got %0d cycles, required 8", sen_count);
        else n_pass++;
        n_total++;
        if (serr_count !== 0) $display("FAIL even_seq_err: got %0d pulses, required 0", serr_count);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL even_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL even_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_odd_and_no_parity();
        logic [0:0] par_seen;
        push_frame(8'hA5, 1'b1, 1'b1);
        send_word(8'hA5, 1'b1, 1'b1, 1'b0);
        capture_frame();
        par_seen = (obs_q.size() > 9) ? obs_q[9] : 1'bx;
        n_total++;
        if (par_seen !== 1'b1) $display("FAIL odd_parity_bit: got %b, required 1", par_seen);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL odd_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL odd_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
        push_frame(8'h80, 1'b0, 1'b0);
        send_word(8'h80, 1'b0, 1'b0, 1'b0);
        capture_frame();
        n_total++;
        if (busy_cycles !== 10 || timed_out !== 1'b0)
            $display("FAIL nopar_busy_len: got %0d (timeout %b), required 10", busy_cycles, timed_out);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL nopar_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL nopar_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        push_frame(8'hC3, 1'b1, 1'b0);
        send_word(8'hC3, 1'b1, 1'b0, 1'b1);
        fork
            capture_frame();
            begin
                repeat (3) @(negedge CLK);
                bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1;
                repeat (3) @(negedge CLK);
                bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
                push_frame(8'h3C, 1'b1, 1'b1);
            end
        join
        n_total++;
        if (busy_cycles !== 11 || timed_out !== 1'b0)
            $display("FAIL b2b_first_len: got %0d (timeout %b), required 11", busy_cycles, timed_out);
        else n_pass++;
        n_total++;
        if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1)
            $display("FAIL b2b_gap: Busy=%b TX_OUT=%b, required 0 1", bus.Busy, bus.TX_OUT);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL b2b_a_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL b2b_a_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
        @(negedge CLK);
        n_total++;
        if (bus.Busy !== 1'b1) $display("FAIL b2b_second_accept: Busy=%b, required 1", bus.Busy);
        else n_pass++;
        bus.Data_Valid = 1'b0;
        capture_frame();
        n_total++;
        if (busy_cycles !== 11 || timed_out !== 1'b0)
            $display("FAIL b2b_second_len: got %0d (timeout %b), required 11", busy_cycles, timed_out);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL b2b_b_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL b2b_b_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_watchdog();
        stall = 1'b1;
        push_frame(8'h5A, 1'b0, 1'b0);
        send_word(8'h5A, 1'b1, 1'b0, 1'b0);
        capture_frame();
        n_total++;
        if (busy_cycles !== 10 || timed_out !== 1'b0)
            $display("FAIL wd_busy_len: got %0d (timeout %b), required 10", busy_cycles, timed_out);
        else n_pass++;
        n_total++;
        if (serr_count !== 1 || serr_pos !== 10)
            $display("FAIL wd_seq_err: count %0d at %0d, required 1 at 10", serr_count, serr_pos);
        else n_pass++;
        n_total++;
        if (fd_count !== 1 || fd_pos !== 10)
            $display("FAIL wd_frame_done: count %0d at %0d, required 1 at 10", fd_count, fd_pos);
        else n_pass++;
        n_total++;
        if (sen_count !== 8) $display("FAIL wd_ser_en: got %0d cycles, required 8", sen_count);
        else n_pass++;
        n_total++;
        if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1 || bus.seq_err !== 1'b0)
            $display("FAIL wd_idle_after: Busy=%b TX_OUT=%b seq_err=%b, required 0 1 0",
                     bus.Busy, bus.TX_OUT, bus.seq_err);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL wd_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL wd_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h0A;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        send_word(d, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            logic [0:0] want;
            if (k > 0) @(negedge CLK);
            want = exp_q.pop_front();
            n_total++;
            if (bus.TX_OUT !== want) $display("FAIL rstmid_bit%0d: TX_OUT=%b, required %b", k, bus.TX_OUT, want);
            else n_pass++;
        end
        RST = 1'b1;
        @(negedge CLK);
        n_total++;
        if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1 || bus.ser_en !== 1'b0 || bus.frame_done !== 1'b0)
            $display("FAIL rstmid_abort: Busy=%b TX_OUT=%b ser_en=%b frame_done=%b, required 0 1 0 0",
                     bus.Busy, bus.TX_OUT, bus.ser_en, bus.frame_done);
        else n_pass++;
        RST = 1'b0;
        push_frame(8'h81, 1'b0, 1'b0);
        send_word(8'h81, 1'b0, 1'b0, 1'b0);
        capture_frame();
        n_total++;
        if (busy_cycles !== 10 || timed_out !== 1'b0)
            $display("FAIL rstmid_new_len: got %0d (timeout %b), required 10", busy_cycles, timed_out);
        else n_pass++;
        for (int k = 0; obs_q.size() > 0; k++) begin
            logic [0:0] got, want;
            got = obs_q.pop_front();
            n_total++;
            if (exp_q.size() == 0) $display("FAIL rstmid_new_bit%0d: TX_OUT=%b, no bit expected", k, got);
            else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL rstmid_new_bit%0d: TX_OUT=%b, required %b", k, got, want);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_and_no_parity();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_frame();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL leftover_expected: %0d bits never observed, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
